// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the memory-port arbiter.
package mem_port_arbiter_pkg;

  // Width codes: data/address width is 1 << (code + 4).
  localparam int unsigned XLEN_32b = 1;
  localparam int unsigned XLEN_64b = 2;

  // Default BUSY-cycle limit before a transaction is abandoned.
  localparam int unsigned MAX_WAIT_DEFAULT = 15;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BUSY_F = 2'd1,
    ST_BUSY_E = 2'd2
  } arb_state_e;

  function automatic int unsigned xlen_width(input int unsigned xlen);
    return 1 << (xlen + 4);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_timer.sv
// Bus wait-state counter: clears while idle, counts BUSY cycles without
// ready, and flags the cycle on which the wait limit is reached.
module mem_port_arbiter_timer
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned MAX_WAIT = MAX_WAIT_DEFAULT
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_expire
);

  logic [7:0] cnt_q;

  // Wait counter: cleared on reset or idle, advanced on each unanswered busy cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      cnt_q <= '0;
    end else if (i_inc) begin
      cnt_q <= cnt_q + 8'd1;
    end
  end

  // High during the MAX_WAIT-th busy cycle, so the bus request drops
  // after exactly MAX_WAIT cycles when no ready arrives.
  assign o_expire = (cnt_q == 8'(MAX_WAIT - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory bus between fetch and execute
// load/store requesters, with wait-state timeout and alternation under
// contention.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter  int unsigned XLEN     = XLEN_64b,
  parameter  int unsigned MAX_WAIT = MAX_WAIT_DEFAULT,
  localparam int unsigned W        = xlen_width(XLEN),
  localparam int unsigned SW       = W / 8
) (
  input  logic          i_clk,
  input  logic          i_rst,
  // fetch port
  input  logic          i_f_req,
  input  logic [W-1:0]  i_f_addr,
  output logic          o_f_valid,
  output logic [W-1:0]  o_f_rdata,
  output logic          o_f_err,
  output logic          o_stall_f,
  // execute port
  input  logic          i_e_req,
  input  logic          i_e_we,
  input  logic [W-1:0]  i_e_addr,
  input  logic [W-1:0]  i_e_wdata,
  input  logic [SW-1:0] i_e_wstrb,
  output logic          o_e_valid,
  output logic [W-1:0]  o_e_rdata,
  output logic          o_e_err,
  output logic          o_stall_e,
  // memory bus
  output logic          o_mem_req,
  output logic          o_mem_we,
  output logic [W-1:0]  o_mem_addr,
  output logic [W-1:0]  o_mem_wdata,
  output logic [SW-1:0] o_mem_wstrb,
  input  logic          i_mem_ready,
  input  logic [W-1:0]  i_mem_rdata
);

  arb_state_e     state_q;
  logic           last_e_q;   // 1 = last completed transaction was execute
  logic           f_valid_q, f_err_q, e_valid_q, e_err_q;
  logic [W-1:0]   f_rdata_q, e_rdata_q;
  logic           mem_req_q, mem_we_q;
  logic [W-1:0]   mem_addr_q, mem_wdata_q;
  logic [SW-1:0]  mem_wstrb_q;

  logic           grant_e;
  logic           busy;
  logic           expire;

  // Execute wins contention unless it was served last.
  assign grant_e = i_e_req && (!i_f_req || !last_e_q);
  assign busy    = (state_q != ST_IDLE);

  mem_port_arbiter_timer #(
    .MAX_WAIT (MAX_WAIT)
  ) u_timer (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_clr    (!busy),
    .i_inc    (busy && !i_mem_ready),
    .o_expire (expire)
  );

  // Arbitration FSM with registered bus command and response outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      last_e_q    <= 1'b0;
      f_valid_q   <= 1'b0;
      f_err_q     <= 1'b0;
      f_rdata_q   <= '0;
      e_valid_q   <= 1'b0;
      e_err_q     <= 1'b0;
      e_rdata_q   <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
    end else begin
      f_valid_q <= 1'b0;
      f_err_q   <= 1'b0;
      e_valid_q <= 1'b0;
      e_err_q   <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (grant_e) begin
            state_q     <= ST_BUSY_E;
            mem_req_q   <= 1'b1;
            mem_we_q    <= i_e_we;
            mem_addr_q  <= i_e_addr;
            mem_wdata_q <= i_e_wdata;
            mem_wstrb_q <= i_e_wstrb;
          end else if (i_f_req) begin
            state_q     <= ST_BUSY_F;
            mem_req_q   <= 1'b1;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= i_f_addr;
            mem_wdata_q <= '0;
            mem_wstrb_q <= '0;
          end
        end
        ST_BUSY_F: begin
          if (i_mem_ready) begin
            state_q   <= ST_IDLE;
            mem_req_q <= 1'b0;
            last_e_q  <= 1'b0;
            f_valid_q <= 1'b1;
            f_rdata_q <= i_mem_rdata;
          end else if (expire) begin
            state_q   <= ST_IDLE;
            mem_req_q <= 1'b0;
            last_e_q  <= 1'b0;
            f_valid_q <= 1'b1;
            f_err_q   <= 1'b1;
            f_rdata_q <= '0;
          end
        end
        ST_BUSY_E: begin
          if (i_mem_ready) begin
            state_q   <= ST_IDLE;
            mem_req_q <= 1'b0;
            last_e_q  <= 1'b1;
            e_valid_q <= 1'b1;
            e_rdata_q <= mem_we_q ? '0 : i_mem_rdata;
          end else if (expire) begin
            state_q   <= ST_IDLE;
            mem_req_q <= 1'b0;
            last_e_q  <= 1'b1;
            e_valid_q <= 1'b1;
            e_err_q   <= 1'b1;
            e_rdata_q <= '0;
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          mem_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign o_f_valid   = f_valid_q;
  assign o_f_rdata   = f_rdata_q;
  assign o_f_err     = f_err_q;
  assign o_e_valid   = e_valid_q;
  assign o_e_rdata   = e_rdata_q;
  assign o_e_err     = e_err_q;
  assign o_mem_req   = mem_req_q;
  assign o_mem_we    = mem_we_q;
  assign o_mem_addr  = mem_addr_q;
  assign o_mem_wdata = mem_wdata_q;
  assign o_mem_wstrb = mem_wstrb_q;

  assign o_stall_f = i_f_req && !f_valid_q;
  assign o_stall_e = i_e_req && !e_valid_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter (64-bit, MAX_WAIT = 15).
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int unsigned W  = 64;
  localparam int unsigned SW = 8;

  logic          clk;
  logic          rst;
  logic          f_req;
  logic [W-1:0]  f_addr;
  logic          f_valid;
  logic [W-1:0]  f_rdata;
  logic          f_err;
  logic          stall_f;
  logic          e_req;
  logic          e_we;
  logic [W-1:0]  e_addr;
  logic [W-1:0]  e_wdata;
  logic [SW-1:0] e_wstrb;
  logic          e_valid;
  logic [W-1:0]  e_rdata;
  logic          e_err;
  logic          stall_e;
  logic          mem_req;
  logic          mem_we;
  logic [W-1:0]  mem_addr;
  logic [W-1:0]  mem_wdata;
  logic [SW-1:0] mem_wstrb;
  logic          mem_ready;
  logic [W-1:0]  mem_rdata;

  int n_cmp = 0;
  int n_err = 0;

  mem_port_arbiter #(
    .XLEN     (XLEN_64b),
    .MAX_WAIT (15)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_f_req     (f_req),
    .i_f_addr    (f_addr),
    .o_f_valid   (f_valid),
    .o_f_rdata   (f_rdata),
    .o_f_err     (f_err),
    .o_stall_f   (stall_f),
    .i_e_req     (e_req),
    .i_e_we      (e_we),
    .i_e_addr    (e_addr),
    .i_e_wdata   (e_wdata),
    .i_e_wstrb   (e_wstrb),
    .o_e_valid   (e_valid),
    .o_e_rdata   (e_rdata),
    .o_e_err     (e_err),
    .o_stall_e   (stall_e),
    .o_mem_req   (mem_req),
    .o_mem_we    (mem_we),
    .o_mem_addr  (mem_addr),
    .o_mem_wdata (mem_wdata),
    .o_mem_wstrb (mem_wstrb),
    .i_mem_ready (mem_ready),
    .i_mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".mem_req"},   64'(mem_req),   64'h0);
    check({tag, ".mem_we"},    64'(mem_we),    64'h0);
    check({tag, ".mem_addr"},  mem_addr,       64'h0);
    check({tag, ".mem_wdata"}, mem_wdata,      64'h0);
    check({tag, ".mem_wstrb"}, 64'(mem_wstrb), 64'h0);
    check({tag, ".f_valid"},   64'(f_valid),   64'h0);
    check({tag, ".f_err"},     64'(f_err),     64'h0);
    check({tag, ".f_rdata"},   f_rdata,        64'h0);
    check({tag, ".e_valid"},   64'(e_valid),   64'h0);
    check({tag, ".e_err"},     64'(e_err),     64'h0);
    check({tag, ".e_rdata"},   e_rdata,        64'h0);
  endtask

  initial begin
    rst = 1'b1; f_req = 1'b0; f_addr = '0;
    e_req = 1'b0; e_we = 1'b0; e_addr = '0; e_wdata = '0; e_wstrb = '0;
    mem_ready = 1'b0; mem_rdata = '0;

    // Reset state
    tick(); tick();
    check_all_zero("reset");
    rst = 1'b0;

    // Fetch only, ready on first busy cycle
    f_req = 1'b1; f_addr = 64'h100;
    #1 check("t1.stall_f.c0", 64'(stall_f), 64'h1);
    tick();
    check("t1.mem_req.c1",  64'(mem_req),   64'h1);
    check("t1.addr.c1",     mem_addr,       64'h100);
    check("t1.we.c1",       64'(mem_we),    64'h0);
    check("t1.wstrb.c1",    64'(mem_wstrb), 64'h0);
    check("t1.stall_f.c1",  64'(stall_f),   64'h1);
    check("t1.f_valid.c1",  64'(f_valid),   64'h0);
    mem_ready = 1'b1; mem_rdata = 64'hDEAD;
    tick();
    check("t1.f_valid.c2",  64'(f_valid),   64'h1);
    check("t1.f_rdata.c2",  f_rdata,        64'hDEAD);
    check("t1.f_err.c2",    64'(f_err),     64'h0);
    check("t1.stall_f.c2",  64'(stall_f),   64'h0);
    check("t1.mem_req.c2",  64'(mem_req),   64'h0);
    f_req = 1'b0; mem_ready = 1'b0;
    tick();
    check("t1.f_valid.c3",  64'(f_valid),   64'h0);

    // Contention: both held, ready immediately -> E, F, E
    f_req = 1'b1; f_addr = 64'h200;
    e_req = 1'b1; e_we = 1'b0; e_addr = 64'h300;
    mem_ready = 1'b1; mem_rdata = 64'hAAAA;
    tick();
    check("t2.addr.g1",     mem_addr,       64'h300);
    check("t2.mem_req.g1",  64'(mem_req),   64'h1);
    check("t2.stall_e.g1",  64'(stall_e),   64'h1);
    tick();
    check("t2.e_valid.v1",  64'(e_valid),   64'h1);
    check("t2.e_rdata.v1",  e_rdata,        64'hAAAA);
    check("t2.f_valid.v1",  64'(f_valid),   64'h0);
    check("t2.stall_e.v1",  64'(stall_e),   64'h0);
    tick();
    check("t2.addr.g2",     mem_addr,       64'h200);
    check("t2.mem_req.g2",  64'(mem_req),   64'h1);
    check("t2.e_valid.g2",  64'(e_valid),   64'h0);
    tick();
    check("t2.f_valid.v2",  64'(f_valid),   64'h1);
    check("t2.e_valid.v2",  64'(e_valid),   64'h0);
    tick();
    check("t2.addr.g3",     mem_addr,       64'h300);
    check("t2.f_valid.g3",  64'(f_valid),   64'h0);
    tick();
    check("t2.e_valid.v3",  64'(e_valid),   64'h1);
    check("t2.f_valid.v3",  64'(f_valid),   64'h0);
    f_req = 1'b0; e_req = 1'b0; mem_ready = 1'b0;
    tick();
    check("t2.mem_req.end", 64'(mem_req),   64'h0);
    check("t2.e_valid.end", 64'(e_valid),   64'h0);

    // Store with 4 wait cycles
    e_req = 1'b1; e_we = 1'b1; e_addr = 64'h400; e_wdata = 64'h1234; e_wstrb = 8'h0F;
    for (int i = 1; i <= 5; i++) begin
      tick();
      check($sformatf("t3.mem_req.c%0d", i), 64'(mem_req),   64'h1);
      check($sformatf("t3.we.c%0d", i),      64'(mem_we),    64'h1);
      check($sformatf("t3.addr.c%0d", i),    mem_addr,       64'h400);
      check($sformatf("t3.wdata.c%0d", i),   mem_wdata,      64'h1234);
      check($sformatf("t3.wstrb.c%0d", i),   64'(mem_wstrb), 64'h0F);
      check($sformatf("t3.e_valid.c%0d", i), 64'(e_valid),   64'h0);
      if (i == 5) begin
        mem_ready = 1'b1; mem_rdata = 64'hBEEF;
      end
    end
    tick();
    check("t3.e_valid", 64'(e_valid), 64'h1);
    check("t3.e_rdata", e_rdata,      64'h0);
    check("t3.e_err",   64'(e_err),   64'h0);
    e_req = 1'b0; e_we = 1'b0; mem_ready = 1'b0;
    tick();

    // Timeout: no ready for 15 busy cycles
    e_req = 1'b1; e_addr = 64'h500;
    for (int i = 1; i <= 15; i++) begin
      tick();
      check($sformatf("t4.mem_req.c%0d", i), 64'(mem_req), 64'h1);
      check($sformatf("t4.e_valid.c%0d", i), 64'(e_valid), 64'h0);
    end
    tick();
    check("t4.mem_req.c16", 64'(mem_req), 64'h0);
    check("t4.e_valid.c16", 64'(e_valid), 64'h1);
    check("t4.e_err.c16",   64'(e_err),   64'h1);
    check("t4.e_rdata.c16", e_rdata,      64'h0);
    e_req = 1'b0;
    tick();
    check("t4.e_valid.c17", 64'(e_valid), 64'h0);
    check("t4.e_err.c17",   64'(e_err),   64'h0);

    // Ready on the 15th busy cycle: normal completion wins
    e_req = 1'b1; e_addr = 64'h580;
    for (int i = 1; i <= 15; i++) begin
      tick();
      check($sformatf("t4b.mem_req.c%0d", i), 64'(mem_req), 64'h1);
      if (i == 15) begin
        mem_ready = 1'b1; mem_rdata = 64'h5555;
      end
    end
    tick();
    check("t4b.e_valid", 64'(e_valid), 64'h1);
    check("t4b.e_err",   64'(e_err),   64'h0);
    check("t4b.e_rdata", e_rdata,      64'h5555);
    e_req = 1'b0; mem_ready = 1'b0;
    tick();

    // Reset during BUSY_E
    e_req = 1'b1; e_addr = 64'h600;
    tick();
    check("t5.mem_req.busy", 64'(mem_req), 64'h1);
    rst = 1'b1; e_req = 1'b0;
    tick();
    check_all_zero("t5.after_rst");
    rst = 1'b0;
    f_req = 1'b1; f_addr = 64'h700;
    tick();
    check("t5.e_valid.post", 64'(e_valid), 64'h0);
    check("t5.mem_req.f",    64'(mem_req), 64'h1);
    check("t5.addr.f",       mem_addr,     64'h700);
    mem_ready = 1'b1; mem_rdata = 64'h7777;
    tick();
    check("t5.f_valid", 64'(f_valid), 64'h1);
    check("t5.f_rdata", f_rdata,      64'h7777);
    check("t5.f_err",   64'(f_err),   64'h0);
    f_req = 1'b0; mem_ready = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
